// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared constants for the ALU control pipeline: instruction classes, function codes,
// ALU control codes and the handshake FSM encoding.
package alu_ctrl_pipe_pkg;

  // ALUop instruction classes
  localparam int unsigned OpCls1  = 1;
  localparam int unsigned OpCls2  = 2;
  localparam int unsigned OpCls3  = 3;
  localparam int unsigned OpCls4  = 4;
  localparam int unsigned OpCls5  = 5;
  localparam int unsigned OpCls6  = 6;
  localparam int unsigned OpCls7  = 7;
  localparam int unsigned OpClsNop = 9;
  localparam int unsigned OpCls10 = 10;

  // Function codes within a class
  localparam int unsigned Fn1 = 1;
  localparam int unsigned Fn2 = 2;
  localparam int unsigned Fn3 = 3;
  localparam int unsigned Fn4 = 4;
  localparam int unsigned Fn5 = 5;
  localparam int unsigned Fn6 = 6;

  typedef enum logic [4:0] {
    Ctrl0   = 5'd0,
    Ctrl1   = 5'd1,
    Ctrl2   = 5'd2,
    Ctrl3   = 5'd3,
    Ctrl4   = 5'd4,
    Ctrl5   = 5'd5,
    Ctrl6   = 5'd6,
    Ctrl7   = 5'd7,
    Ctrl8   = 5'd8,
    Ctrl9   = 5'd9,
    Ctrl10  = 5'd10,
    Ctrl11  = 5'd11,
    Ctrl12  = 5'd12,
    Ctrl13  = 5'd13,
    Ctrl14  = 5'd14,
    Ctrl15  = 5'd15,
    Ctrl16  = 5'd16,
    CtrlNop = 5'd17
  } ctrl_e;

  typedef enum logic [1:0] {
    StEmpty  = 2'd0,
    StFull   = 2'd1,
    StMcWait = 2'd2
  } state_e;

  function automatic logic is_multi_cycle(ctrl_e c);
    return c inside {Ctrl6, Ctrl7, Ctrl9, Ctrl16};
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// Handshake bundle between the instruction source and the ALU control pipeline.
interface alu_ctrl_pipe_if #(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned FN_W   = 6,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned CNT_W  = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   alu_op;
  logic [FN_W-1:0]   fn_code;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              illegal;
  logic              multi_cycle;
  logic [CNT_W-1:0]  illegal_count;

  modport master (
    output in_valid, alu_op, fn_code, out_ready,
    input  in_ready, out_valid, alu_ctrl, illegal, multi_cycle, illegal_count
  );

  modport slave (
    input  in_valid, alu_op, fn_code, out_ready,
    output in_ready, out_valid, alu_ctrl, illegal, multi_cycle, illegal_count
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/fn_code to ALU control decode; anything unlisted becomes an illegal NOP.
module alu_ctrl_decode
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned FN_W   = 6,
  parameter int unsigned CTRL_W = 5
) (
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FN_W-1:0]   fn_code,
  output logic [CTRL_W-1:0] code,
  output logic              illegal,
  output logic              multi_cycle
);

  ctrl_e code5;

  always_comb begin
    code5   = CtrlNop;
    illegal = 1'b1;
    case (alu_op)
      OP_W'(OpCls1): begin
        case (fn_code)
          FN_W'(Fn1): begin code5 = Ctrl0; illegal = 1'b0; end
          FN_W'(Fn2): begin code5 = Ctrl1; illegal = 1'b0; end
          FN_W'(Fn3): begin code5 = Ctrl2; illegal = 1'b0; end
          FN_W'(Fn4): begin code5 = Ctrl3; illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_W'(OpCls2): begin
        case (fn_code)
          FN_W'(Fn1): begin code5 = Ctrl0; illegal = 1'b0; end
          FN_W'(Fn2): begin code5 = Ctrl1; illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_W'(OpCls3): begin
        case (fn_code)
          FN_W'(Fn1): begin code5 = Ctrl6; illegal = 1'b0; end
          FN_W'(Fn2): begin code5 = Ctrl7; illegal = 1'b0; end
          FN_W'(Fn3): begin code5 = Ctrl9; illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_W'(OpCls4): begin
        case (fn_code)
          FN_W'(Fn1): begin code5 = Ctrl4; illegal = 1'b0; end
          FN_W'(Fn2): begin code5 = Ctrl5; illegal = 1'b0; end
          FN_W'(Fn3): begin code5 = Ctrl8; illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_W'(OpCls5), OP_W'(OpCls6): begin
        if (fn_code == FN_W'(Fn1)) begin
          code5   = Ctrl0;
          illegal = 1'b0;
        end
      end
      OP_W'(OpCls7): begin
        case (fn_code)
          FN_W'(Fn1): begin code5 = Ctrl10; illegal = 1'b0; end
          FN_W'(Fn2): begin code5 = Ctrl11; illegal = 1'b0; end
          FN_W'(Fn3): begin code5 = Ctrl12; illegal = 1'b0; end
          FN_W'(Fn4): begin code5 = Ctrl13; illegal = 1'b0; end
          FN_W'(Fn5): begin code5 = Ctrl14; illegal = 1'b0; end
          FN_W'(Fn6): begin code5 = Ctrl15; illegal = 1'b0; end
          default: ;
        endcase
      end
      // Explicit NOP class: legal regardless of the function code
      OP_W'(OpClsNop): illegal = 1'b0;
      OP_W'(OpCls10): begin
        if (fn_code == FN_W'(Fn1)) begin
          code5   = Ctrl16;
          illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign code        = CTRL_W'(code5);
  assign multi_cycle = is_multi_cycle(code5);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// One-deep registered ALU control decode with valid/ready handshake, a stall window after
// multi-cycle ops, and a saturating count of accepted illegal pairs.
module alu_ctrl_pipe
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned FN_W   = 6,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned MC_LAT = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_ctrl_pipe_if.slave bus
);

  localparam int unsigned STALL_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [STALL_W-1:0] StallLoad = STALL_W'(MC_LAT - 1);
  localparam logic [CNT_W-1:0]   CntMax    = '1;

  logic [CTRL_W-1:0]  dec_code;
  logic               dec_illegal;
  logic               dec_mc;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CTRL_W-1:0]  ctrl_q;
  logic               illegal_q;
  logic               mc_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load;
  logic               out_valid;
  logic               ready_fsm;

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .FN_W   (FN_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .alu_op      (bus.alu_op),
    .fn_code     (bus.fn_code),
    .code        (dec_code),
    .illegal     (dec_illegal),
    .multi_cycle (dec_mc)
  );

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    load      = 1'b0;
    out_valid = 1'b0;
    ready_fsm = 1'b0;
    case (state_q)
      StEmpty: begin
        ready_fsm = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        out_valid = 1'b1;
        ready_fsm = bus.out_ready & ~mc_q;
        if (bus.out_ready) begin
          if (mc_q) begin
            state_d = StMcWait;
            stall_d = StallLoad;
          end else if (bus.in_valid) begin
            load = 1'b1;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      StMcWait: begin
        if (stall_q == '0) begin
          state_d = StEmpty;
        end else begin
          stall_d = stall_q - STALL_W'(1);
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load && dec_illegal && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      stall_q   <= '0;
      ctrl_q    <= CTRL_W'(CtrlNop);
      illegal_q <= 1'b0;
      mc_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      if (load) begin
        ctrl_q    <= dec_code;
        illegal_q <= dec_illegal;
        mc_q      <= dec_mc;
      end
    end
  end

  // Reset must never let a pair be accepted, even though the FSM state is not yet EMPTY
  assign bus.in_ready      = ready_fsm & ~rst;
  assign bus.out_valid     = out_valid;
  assign bus.alu_ctrl      = ctrl_q;
  assign bus.illegal       = illegal_q;
  assign bus.multi_cycle   = mc_q;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_alu_ctrl_pipe;

  localparam int MC_LAT  = 2;
  localparam int CNT_MAX = 255;

  logic clk;
  logic rst;
  bit   chk_en;
  int   n_chk;
  int   n_err;

  // Model state: held op, remaining stall cycles, illegal count
  bit m_valid;
  int m_code;
  bit m_ill;
  bit m_mc;
  int m_stall;
  int m_cnt;

  alu_ctrl_pipe_if #(.OP_W(4), .FN_W(6), .CTRL_W(5), .CNT_W(8)) bus ();
  alu_ctrl_pipe_if #(.OP_W(4), .FN_W(6), .CTRL_W(5), .CNT_W(2)) bus2 ();

  alu_ctrl_pipe #(
    .OP_W(4), .FN_W(6), .CTRL_W(5), .MC_LAT(MC_LAT), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_ctrl_pipe #(
    .OP_W(4), .FN_W(6), .CTRL_W(5), .MC_LAT(1), .CNT_W(2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input int op, input int fn, output int code,
                                     output bit ill, output bit mc);
    code = 17;
    ill  = 1'b0;
    if (op == 9) code = 17;
    else if (op == 1 && fn >= 1 && fn <= 4) code = fn - 1;
    else if (op == 2 && fn >= 1 && fn <= 2) code = fn - 1;
    else if (op == 3 && fn >= 1 && fn <= 3) code = (fn == 3) ? 9 : fn + 5;
    else if (op == 4 && fn >= 1 && fn <= 3) code = (fn == 3) ? 8 : fn + 3;
    else if ((op == 5 || op == 6) && fn == 1) code = 0;
    else if (op == 7 && fn >= 1 && fn <= 6) code = fn + 9;
    else if (op == 10 && fn == 1) code = 16;
    else ill = 1'b1;
    mc = (code == 6 || code == 7 || code == 9 || code == 16);
  endfunction

  function automatic bit model_ready();
    if (rst || m_stall > 0) return 1'b0;
    if (!m_valid) return 1'b1;
    return bus.out_ready && !m_mc;
  endfunction

  // Compare, then advance the model over the coming rising edge using the current inputs
  always begin
    bit rdy;
    @(negedge clk);
    #3;
    if (chk_en) begin
      chk("out_valid", bus.out_valid, m_valid);
      chk("in_ready", bus.in_ready, model_ready());
      chk("illegal_count", bus.illegal_count, m_cnt);
      if (m_valid) begin
        chk("alu_ctrl", bus.alu_ctrl, m_code);
        chk("illegal", bus.illegal, m_ill);
        chk("multi_cycle", bus.multi_cycle, m_mc);
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      m_stall = 0;
      m_cnt   = 0;
    end else begin
      rdy = model_ready();
      if (m_stall > 0) m_stall--;
      if (m_valid && bus.out_ready) begin
        m_stall = m_mc ? MC_LAT : 0;
        m_valid = 1'b0;
      end
      if (bus.in_valid && rdy) begin
        ref_decode(int'(bus.alu_op), int'(bus.fn_code), m_code, m_ill, m_mc);
        m_valid = 1'b1;
        if (m_ill && m_cnt < CNT_MAX) m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int op, input int fn, input bit ordy);
    bus.in_valid  = v;
    bus.alu_op    = 4'(op);
    bus.fn_code   = 6'(fn);
    bus.out_ready = ordy;
  endtask

  task automatic drive2(input bit v, input int op, input int fn);
    bus2.in_valid  = v;
    bus2.alu_op    = 4'(op);
    bus2.fn_code   = 6'(fn);
    bus2.out_ready = 1'b1;
  endtask

  initial begin
    int legal_ops [9];
    int op;
    int fn;
    legal_ops = '{1, 2, 3, 4, 5, 6, 7, 9, 10};
    n_chk = 0;
    n_err = 0;
    chk_en = 1'b0;
    m_valid = 1'b0; m_code = 17; m_ill = 1'b0; m_mc = 1'b0; m_stall = 0; m_cnt = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    drive2(0, 0, 0);
    @(negedge clk);
    #1;
    tick();
    chk_en = 1'b1;

    // Reset state
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst alu_ctrl", bus.alu_ctrl, 17);
    chk("rst illegal", bus.illegal, 0);
    chk("rst multi_cycle", bus.multi_cycle, 0);
    chk("rst illegal_count", bus.illegal_count, 0);
    chk("rst in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", bus.in_ready, 1);

    // Back-to-back single-cycle ops
    drive(1, 1, 3, 1);
    tick();
    chk("b2b first", bus.alu_ctrl, 2);
    chk("b2b first valid", bus.out_valid, 1);
    chk("b2b first ready", bus.in_ready, 1);
    drive(1, 7, 5, 1);
    tick();
    chk("b2b second", bus.alu_ctrl, 14);
    chk("b2b second valid", bus.out_valid, 1);
    chk("b2b second ready", bus.in_ready, 1);
    drive(0, 0, 0, 1);
    tick();
    chk("b2b drain", bus.out_valid, 0);

    // Illegal pairs and the NOP class
    drive(1, 2, 3, 1);
    tick();
    chk("ill c2f3 ctrl", bus.alu_ctrl, 17);
    chk("ill c2f3 flag", bus.illegal, 1);
    drive(1, 12, 1, 1);
    tick();
    chk("ill c12 ctrl", bus.alu_ctrl, 17);
    chk("ill c12 flag", bus.illegal, 1);
    chk("ill count", bus.illegal_count, 2);
    drive(1, 9, 0, 1);
    tick();
    chk("nop ctrl", bus.alu_ctrl, 17);
    chk("nop illegal", bus.illegal, 0);
    chk("nop count", bus.illegal_count, 2);
    drive(0, 0, 0, 1);
    tick();

    // Backpressure holds the output stable
    drive(1, 4, 1, 0);
    tick();
    drive(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold ctrl", bus.alu_ctrl, 4);
      chk("hold valid", bus.out_valid, 1);
      chk("hold ready", bus.in_ready, 0);
      tick();
    end
    drive(0, 0, 0, 1);
    tick();
    chk("hold drain", bus.out_valid, 0);

    // Multi-cycle op stalls for MC_LAT cycles
    drive(1, 3, 2, 1);
    tick();
    chk("mc ctrl", bus.alu_ctrl, 7);
    chk("mc flag", bus.multi_cycle, 1);
    chk("mc full ready", bus.in_ready, 0);
    drive(1, 1, 1, 1);
    tick();
    chk("mc stall1 ready", bus.in_ready, 0);
    chk("mc stall1 valid", bus.out_valid, 0);
    tick();
    chk("mc stall2 ready", bus.in_ready, 0);
    tick();
    chk("mc empty ready", bus.in_ready, 1);
    chk("mc empty valid", bus.out_valid, 0);
    drive(0, 0, 0, 1);
    tick();

    // Reset during the first stall cycle
    drive(1, 3, 1, 1);
    tick();
    chk("mcrst ctrl", bus.alu_ctrl, 6);
    drive(0, 0, 0, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("mcrst ready in rst", bus.in_ready, 0);
    tick();
    chk("mcrst valid", bus.out_valid, 0);
    chk("mcrst ctrl nop", bus.alu_ctrl, 17);
    rst = 1'b0;
    #1;
    chk("mcrst ready after", bus.in_ready, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 8)]
                                      : int'($urandom_range(0, 15));
      fn = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 7))
                                      : int'($urandom_range(0, 63));
      drive($urandom_range(0, 9) < 7, op, fn, $urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b1;
    drive(0, 0, 0, 1);
    tick();
    rst = 1'b0;

    // Narrow counter saturates; single-cycle stall window
    drive2(1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sat count", bus2.illegal_count, (k < 3) ? k : 3);
    end
    drive2(1, 10, 1);
    tick();
    chk("lat1 ctrl", bus2.alu_ctrl, 16);
    chk("lat1 mc", bus2.multi_cycle, 1);
    chk("lat1 full ready", bus2.in_ready, 0);
    drive2(0, 0, 0);
    tick();
    chk("lat1 stall ready", bus2.in_ready, 0);
    chk("lat1 stall valid", bus2.out_valid, 0);
    tick();
    chk("lat1 empty ready", bus2.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
